// File: rtl/reg_wb_arb.sv
// -----------------------------------------------------------------------------
// reg_wb_arb -- register-file write-back arbiter
//
// Merges two write sources into one registered write port:
//   * ALU results: always accepted, highest priority, never stall.
//   * Load results: handshaked through mem_valid/mem_ready, buffered in a
//     DEPTH-entry FIFO when they lose the write port to the ALU.
// Each queued load carries a live bit. A younger ALU write to the same
// register squashes it, so an older value never overwrites a newer one.
// q_pending lets the issue logic ask whether a write to q_reg is in flight.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   alu_valid/alu_reg/alu_data     ALU write request (no backpressure)
//   mem_valid/mem_ready            load handshake
//   mem_reg/mem_data               load write request
//   regwrite/wrreg/wrdata          registered register-file write port
//   q_reg/q_pending                combinational hazard query
// -----------------------------------------------------------------------------
module reg_wb_arb #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_reg,
    input  logic [31:0] mem_data,
    output logic        regwrite,
    output logic [4:0]  wrreg,
    output logic [31:0] wrdata,
    input  logic [4:0]  q_reg,
    output logic        q_pending
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    localparam cnt_t FULL = cnt_t'(DEPTH);

    ptr_t             r_rd_ptr;
    ptr_t             r_wr_ptr;
    cnt_t             r_count;
    logic [DEPTH-1:0] r_live;
    logic [4:0]       r_q_reg  [DEPTH];
    logic [31:0]      r_q_data [DEPTH];

    logic w_alu_acc;
    logic w_mem_acc;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_push_live;
    logic w_hit;

    // Register 0 is hard-wired, so writes to it are dropped at the door.
    assign w_alu_acc   = alu_valid && (alu_reg != 5'd0);
    assign w_mem_acc   = mem_valid && mem_ready && (mem_reg != 5'd0);
    assign w_empty     = (r_count == cnt_t'(0));

    // The ALU owns the write port whenever it writes; otherwise the queue
    // head goes first so loads keep acceptance order, and only an empty
    // queue lets a fresh load bypass straight to the output.
    assign w_pop       = !w_alu_acc && !w_empty;
    assign w_push      = w_mem_acc && (w_alu_acc || !w_empty);

    // A load colliding with a same-cycle ALU write is the older value.
    assign w_push_live = !(w_alu_acc && (alu_reg == mem_reg));

    assign mem_ready   = rst_n && (r_count < FULL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwrite <= 1'b0;
            wrreg    <= 5'd0;
            wrdata   <= 32'd0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_live   <= '0;
        end else begin
            if (w_alu_acc) begin
                regwrite <= 1'b1;
                wrreg    <= alu_reg;
                wrdata   <= alu_data;
            end else if (w_pop) begin
                // A squashed head still burns its slot, just without a strobe.
                regwrite <= r_live[r_rd_ptr];
                wrreg    <= r_q_reg[r_rd_ptr];
                wrdata   <= r_q_data[r_rd_ptr];
            end else if (w_mem_acc) begin
                regwrite <= 1'b1;
                wrreg    <= mem_reg;
                wrdata   <= mem_data;
            end else begin
                regwrite <= 1'b0;
            end

            // Later non-blocking writes to the same live bit win, so the
            // squash, pop-clear and push-set order below is deliberate.
            if (w_alu_acc) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_q_reg[i] == alu_reg) r_live[i] <= 1'b0;
                end
            end
            if (w_pop) begin
                r_live[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= r_rd_ptr + ptr_t'(1);
            end
            if (w_push) begin
                r_live[r_wr_ptr] <= w_push_live;
                r_wr_ptr         <= r_wr_ptr + ptr_t'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + cnt_t'(1);
                2'b01:   r_count <= r_count - cnt_t'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the payload array has no reset; stale contents are never
    // observable because the live bits and count are reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_reg[r_wr_ptr]  <= mem_reg;
            r_q_data[r_wr_ptr] <= mem_data;
        end
    end

    // Free slots always have live=0, so scanning all entries is safe.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i] && (r_q_reg[i] == q_reg)) w_hit = 1'b1;
        end
    end

    assign q_pending = rst_n && (q_reg != 5'd0) &&
                       ((regwrite && (wrreg == q_reg)) || w_hit);

endmodule

// File: doc/reg_wb_arb.md
REG_WB_ARB -- requirements
Module: reg_wb_arb

Interface
REQ-001 Parameter DEPTH, default 4: mem-result queue entries; power of two, at least 2.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 alu_valid  input  1  ALU result present this cycle; no backpressure, always accepted.
REQ-005 alu_reg  input  5  ALU destination register.
REQ-006 alu_data  input  32  ALU result.
REQ-007 mem_valid  input  1  load result offered.
REQ-008 mem_ready  output  1  queue can accept a load result; equals (count < DEPTH) from registered state.
REQ-009 mem_reg  input  5  load destination register.
REQ-010 mem_data  input  32  load result.
REQ-011 regwrite  output  1  registered write strobe to the register file.
REQ-012 wrreg  output  5  registered write address.
REQ-013 wrdata  output  32  registered write data.
REQ-014 q_reg  input  5  hazard query register.
REQ-015 q_pending  output  1  combinational; high when a live write to q_reg is queued or is on the output stage.

Function
REQ-016 Load accepted = mem_valid && mem_ready. ALU write accepted = alu_valid.
REQ-017 Writes with destination 0 are discarded at acceptance: no enqueue, no output strobe, no squash effect.
REQ-018 Output-stage priority, evaluated each cycle: (1) accepted ALU write; (2) queue head when the queue is non-empty; (3) accepted load when the queue is empty. With none of these, regwrite=0 next cycle.
REQ-019 Latency: an accepted write reaches regwrite/wrreg/wrdata on the next rising edge when it wins priority; otherwise it waits in the queue.
REQ-020 An accepted load that does not win the output stage is pushed at the tail. Push and pop may occur in the same cycle; count then remains unchanged.
REQ-021 Queue is FIFO: circular read/write pointers of log2(DEPTH) bits that wrap DEPTH-1 -> 0, plus a count of width log2(DEPTH)+1.
REQ-022 Each entry holds a live bit. An accepted ALU write to register r clears the live bit of every queued entry with reg r. It also clears the live bit of a load to r that is pushed in the same cycle.
REQ-023 Popping a non-live entry consumes the output slot with regwrite=0. The pop still advances the pointer and decrements count.
REQ-024 Same-cycle accepted ALU and load writes to the same register r: the ALU value is written and the load is dropped. The load is treated as older.
REQ-025 When the queue is full, mem_ready=0 and mem_valid is ignored. mem_ready rises on the cycle after a pop that frees a slot.
REQ-026 q_pending = (regwrite && wrreg==q_reg) || (some live entry has reg==q_reg). Forced to 0 when q_reg==0.
REQ-027 Load results are written in acceptance order. A write to a given register is never overwritten by an older write to the same register.

Reset
REQ-028 When rst_n=0 at a rising edge: regwrite=0, wrreg=0, wrdata=0, count=0, both pointers=0, all live bits=0.
REQ-029 While rst_n=0: mem_ready=0, q_pending=0, and all inputs are ignored.
REQ-030 Reset during operation discards all queued writes. mem_ready=1 on the first cycle after rst_n returns high.

Verification
REQ-031 Load-only bypass: queue empty, alu_valid=0, load (reg 5, 0xDEADBEEF) -> next cycle regwrite=1, wrreg=5, wrdata=0xDEADBEEF, count stays 0.
REQ-032 Collision and drain: ALU (reg 3, 0x11) and load (reg 4, 0x22) in the same cycle -> write 3/0x11, then 4/0x22 the following cycle.
REQ-033 Full queue: alu_valid held high with loads to regs 6,7,8,9 accepted -> mem_ready=0 after the 4th. With alu_valid low, the loads drain as 6,7,8,9 and mem_ready returns to 1.
REQ-034 Squash: load (reg 10, 0xAA) queued, then ALU (reg 10, 0xBB) -> only 10/0xBB is written. The pop slot for the queued load shows regwrite=0. q_pending(10) drops after the 0xBB write retires.
REQ-035 Register zero: ALU and load to reg 0 -> no regwrite pulses, count unchanged, q_pending(0)=0.
REQ-036 Mid-operation reset: 3 entries queued, rst_n=0 for one edge -> all outputs 0, count 0; mem_ready=1 and no stale writes emerge afterwards.
